convcode_frame_ctrl: RTL and testbench

//  Frame sequencer for the convolutional-code test chain (PN source -> rate-1/2 encoder -> 2:1 serializer
//  -> noise injector -> decoder). Frames FRAME_LEN info bits, flushes encoder with K-1 zero tail bits,

---
 rtl/convcode_frame_ctrl_pkg.sv | 23 ++
 rtl/convcode_frame_ctrl_seg_timer.sv | 28 ++
 rtl/convcode_frame_ctrl.sv | 141 ++++++++++++++
 tb/tb_convcode_frame_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/convcode_frame_ctrl_pkg.sv
// Shared state encodings and default sizing for the conv-code test chain.
// Imported by the frame sequencer and its segment timer.
package convcode_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    TAIL  = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int FRAME_LEN_DEF  = 64;
  localparam int CONSTR_LEN_DEF = 3;
  localparam int DEC_LAT_DEF    = 32;
  localparam int GAP_LEN_DEF    = 4;
  localparam int CNT_W_DEF      = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/convcode_frame_ctrl_seg_timer.sv
// Loadable down-counter timing every segment of a frame.
// Zero flag marks the last cycle of the current segment.
module convcode_seg_timer
  import convcode_frame_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && !zero)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/convcode_frame_ctrl.sv
// Frame sequencer: PN source, encoder pacing, tail flush, noise gating,
// decoder start/flush and completed-frame counting.
module convcode_frame_ctrl
  import convcode_frame_ctrl_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int CONSTR_LEN = CONSTR_LEN_DEF,
  parameter int DEC_LAT    = DEC_LAT_DEF,
  parameter int GAP_LEN    = GAP_LEN_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk20M_sig,
  input  logic             reset_sig,
  input  logic             start_sig,
  input  logic             cont_mode_sig,
  input  logic             stop_sig,
  input  logic             noise_req_sig,
  output logic             src_ce_sig,
  output logic             enc_ce_sig,
  output logic             enc_tail_sig,
  output logic             ser_sel_sig,
  output logic             ser_valid_sig,
  output logic             noise_en_sig,
  output logic             dec_start_sig,
  output logic             dec_flush_sig,
  output logic             busy_sig,
  output logic             frame_done_sig,
  output logic [CNT_W-1:0] frame_cnt_sig
);

  localparam int DATA_CYC = 2 * FRAME_LEN;
  localparam int TAIL_CYC = 2 * (CONSTR_LEN - 1);
  localparam int SEG_MAX  = max2(max2(DATA_CYC, DEC_LAT),
                                 max2(GAP_LEN, TAIL_CYC));
  localparam int SEG_W    = $clog2(SEG_MAX + 1);

  localparam logic [SEG_W-1:0] DATA_LD  = SEG_W'(DATA_CYC - 1);
  localparam logic [SEG_W-1:0] TAIL_LD  = SEG_W'(TAIL_CYC - 1);
  localparam logic [SEG_W-1:0] DRAIN_LD = SEG_W'(DEC_LAT - 1);
  localparam logic [SEG_W-1:0] GAP_LD   = SEG_W'(GAP_LEN - 1);
  localparam logic [SEG_W-1:0] ONE      = SEG_W'(1);

  state_t           state;
  state_t           nxt;
  logic             ph;
  logic             nxt_ph;
  logic             noise_lat;
  logic             nxt_lat;
  logic             seg_load;
  logic [SEG_W-1:0] ld_val;
  logic [SEG_W-1:0] seg_cnt;
  logic             seg_zero;
  logic             nxt_sym;
  logic             last_drain;

  convcode_seg_timer #(.W(SEG_W)) u_timer (
    .clk      (clk20M_sig),
    .rst      (reset_sig),
    .load     (seg_load),
    .load_val (ld_val),
    .en       (!seg_load),
    .cnt      (seg_cnt),
    .zero     (seg_zero)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if ((start_sig || cont_mode_sig) && !stop_sig) nxt = DATA;
      DATA:  if (stop_sig) nxt = IDLE; else if (seg_zero) nxt = TAIL;
      TAIL:  if (stop_sig) nxt = IDLE; else if (seg_zero) nxt = DRAIN;
      DRAIN: if (stop_sig) nxt = IDLE; else if (seg_zero) nxt = GAP;
      GAP:   if (stop_sig) nxt = IDLE; else if (seg_zero) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    seg_load = (nxt != state);
    ld_val   = '0;
    unique case (nxt)
      DATA:    ld_val = DATA_LD;
      TAIL:    ld_val = TAIL_LD;
      DRAIN:   ld_val = DRAIN_LD;
      GAP:     ld_val = GAP_LD;
      default: ld_val = '0;
    endcase
  end

  // Phase restarts at 0 on every DATA entry; the even DATA length keeps TAIL aligned.
  always_comb begin
    nxt_sym = (nxt == DATA) || (nxt == TAIL);
    nxt_ph  = 1'b0;
    if (nxt_sym && (state == DATA || state == TAIL))
      nxt_ph = ~ph;
    nxt_lat = noise_lat;
    if (state == IDLE && nxt == DATA)
      nxt_lat = noise_req_sig;
    else if (nxt == IDLE)
      nxt_lat = 1'b0;
    last_drain = 1'b0;
    if (nxt == DRAIN)
      last_drain = (state == DRAIN) ? (seg_cnt == ONE) : (DEC_LAT == 1);
  end

  always_ff @(posedge clk20M_sig) begin
    if (reset_sig) begin
      state          <= IDLE;
      ph             <= 1'b0;
      noise_lat      <= 1'b0;
      src_ce_sig     <= 1'b0;
      enc_ce_sig     <= 1'b0;
      enc_tail_sig   <= 1'b0;
      ser_sel_sig    <= 1'b0;
      ser_valid_sig  <= 1'b0;
      noise_en_sig   <= 1'b0;
      dec_start_sig  <= 1'b0;
      dec_flush_sig  <= 1'b0;
      busy_sig       <= 1'b0;
      frame_done_sig <= 1'b0;
      frame_cnt_sig  <= '0;
    end else begin
      state          <= nxt;
      ph             <= nxt_ph;
      noise_lat      <= nxt_lat;
      src_ce_sig     <= (nxt == DATA) && nxt_ph;
      enc_ce_sig     <= nxt_sym && nxt_ph;
      enc_tail_sig   <= (nxt == TAIL);
      ser_sel_sig    <= nxt_ph;
      ser_valid_sig  <= nxt_sym;
      noise_en_sig   <= nxt_sym && nxt_lat;
      dec_start_sig  <= (state == IDLE) && (nxt == DATA);
      dec_flush_sig  <= (nxt == DRAIN);
      busy_sig       <= (nxt != IDLE);
      frame_done_sig <= last_drain;
      if (last_drain)
        frame_cnt_sig <= frame_cnt_sig + 1'b1;
    end
  end

endmodule

// File: tb/tb_convcode_frame_ctrl.sv
// Scoreboard bench for convcode_frame_ctrl with a frame-position model.
// Stimulus pushes expected outputs; a monitor pops and compares each cycle.
module tb_convcode_frame_ctrl;

  localparam int FL    = 8;
  localparam int KL    = 3;
  localparam int DL    = 4;
  localparam int GL    = 2;
  localparam int CW    = 2;
  localparam int D_END = 2 * FL;
  localparam int T_END = D_END + 2 * (KL - 1);
  localparam int R_END = T_END + DL;
  localparam int SPAN  = R_END + GL;

  logic          clk = 1'b0;
  logic          reset_sig = 1'b1;
  logic          start_sig = 1'b0;
  logic          cont_mode_sig = 1'b0;
  logic          stop_sig = 1'b0;
  logic          noise_req_sig = 1'b0;
  logic          src_ce_sig, enc_ce_sig, enc_tail_sig, ser_sel_sig;
  logic          ser_valid_sig, noise_en_sig, dec_start_sig;
  logic          dec_flush_sig, busy_sig, frame_done_sig;
  logic [CW-1:0] frame_cnt_sig;

  typedef struct packed {
    logic src, enc, tail, sel, valid, noise;
    logic dstart, flush, busy, done;
  } flags_t;

  typedef struct packed {
    flags_t        f;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   pos = 0;
  bit   lat = 1'b0;
  int   fcnt = 0;
  int   cyc = 0;
  bit   cont = 1'b0;

  convcode_frame_ctrl #(
    .FRAME_LEN(FL), .CONSTR_LEN(KL), .DEC_LAT(DL),
    .GAP_LEN(GL), .CNT_W(CW)
  ) dut (
    .clk20M_sig     (clk),
    .reset_sig      (reset_sig),
    .start_sig      (start_sig),
    .cont_mode_sig  (cont_mode_sig),
    .stop_sig       (stop_sig),
    .noise_req_sig  (noise_req_sig),
    .src_ce_sig     (src_ce_sig),
    .enc_ce_sig     (enc_ce_sig),
    .enc_tail_sig   (enc_tail_sig),
    .ser_sel_sig    (ser_sel_sig),
    .ser_valid_sig  (ser_valid_sig),
    .noise_en_sig   (noise_en_sig),
    .dec_start_sig  (dec_start_sig),
    .dec_flush_sig  (dec_flush_sig),
    .busy_sig       (busy_sig),
    .frame_done_sig (frame_done_sig),
    .frame_cnt_sig  (frame_cnt_sig)
  );

  always #5 clk = ~clk;

  // Expected outputs from the position within a frame (1 = first DATA cycle).
  function automatic exp_t predict();
    exp_t e;
    bit   v  = (pos >= 1) && (pos <= T_END);
    bit   ph = v && (((pos - 1) % 2) == 1);
    e.f.src    = ph && (pos <= D_END);
    e.f.enc    = ph;
    e.f.tail   = (pos > D_END) && (pos <= T_END);
    e.f.sel    = ph;
    e.f.valid  = v;
    e.f.noise  = v && lat;
    e.f.dstart = (pos == 1);
    e.f.flush  = (pos > T_END) && (pos <= R_END);
    e.f.busy   = (pos != 0);
    e.f.done   = (pos == R_END);
    e.cnt      = CW'(fcnt);
    return e;
  endfunction

  task automatic step(input bit r, input bit s, input bit c,
                      input bit p, input bit n);
    @(negedge clk);
    reset_sig     = r;
    start_sig     = s;
    cont_mode_sig = c;
    stop_sig      = p;
    noise_req_sig = n;
    if (r) begin
      pos = 0; lat = 1'b0; fcnt = 0;
    end else if (pos == 0) begin
      if ((s || c) && !p) begin
        pos = 1; lat = n;
      end
    end else if (p) begin
      pos = 0;
    end else begin
      pos = (pos == SPAN) ? 0 : pos + 1;
      if (pos == R_END) fcnt = (fcnt + 1) % (1 << CW);
    end
    q.push_back(predict());
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t   e;
    flags_t a;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{src_ce_sig, enc_ce_sig, enc_tail_sig, ser_sel_sig,
              ser_valid_sig, noise_en_sig, dec_start_sig,
              dec_flush_sig, busy_sig, frame_done_sig};
        total++;
        if (a !== e.f) begin
          bad++;
          $display("FAIL flags cyc=%0d got=%b exp=%b", cyc, a, e.f);
        end
        total++;
        if (frame_cnt_sig !== e.cnt) begin
          bad++;
          $display("FAIL frame_cnt cyc=%0d got=%0d exp=%0d",
                   cyc, frame_cnt_sig, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // noise requested at start, dropped mid-DATA
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(30);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(30);
    // five back-to-back frames in continuous mode
    repeat (5 * (SPAN + 1))
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom % 2));
    idle(30);
    // abort during the 5th DATA cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    // reset during TAIL, then a clean frame
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(17);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(30);
    // start and stop together stays idle
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    repeat (600) begin
      if ($urandom_range(0, 39) == 0) cont = ~cont;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
           cont, $urandom_range(0, 49) == 0, 1'($urandom % 2));
    end
    idle(5);
    repeat (3) @(posedge clk);
    #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d left exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
